nms_stream_pipe: RTL and testbench

//  Streaming, parametrised non-maximal suppression stage of the Canny pipeline; sits between gradient/direction and hysteresis.

---
 rtl/nms_pkg.sv | 10 +
 rtl/nms_stream_pipe_if.sv | 27 ++
 rtl/nms_line_buffer.sv | 46 ++++
 rtl/nms_stream_pipe.sv | 163 ++++++++++++++++
 tb/tb_nms_stream_pipe.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nms_pkg.sv
// Shared types for the streaming non-maximal suppression stage.
package nms_pkg;

  localparam int unsigned DIR_W = 2;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} nms_state_t;

  typedef enum logic [DIR_W-1:0] {DIR_0, DIR_45, DIR_90, DIR_135} nms_dir_t;

endpackage

// File: rtl/nms_stream_pipe_if.sv
// Pixel stream in/out handshake bundle for nms_stream_pipe.
interface nms_stream_pipe_if
  import nms_pkg::*;
#(
  parameter int unsigned MAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [MAG_W-1:0] in_mag;
  logic [DIR_W-1:0] in_dir;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W-1:0] out_mag;
  logic             out_sof;
  logic             out_eof;

  modport master (
    output in_valid, in_mag, in_dir, in_sof, out_ready,
    input  in_ready, out_valid, out_mag, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_mag, in_dir, in_sof, out_ready,
    output in_ready, out_valid, out_mag, out_sof, out_eof
  );
endinterface

// File: rtl/nms_line_buffer.sv
// Two chained line-deep shift lines plus two top-row tap stages; exposes the 3x3
// window whose bottom-right tap is the pixel being accepted this cycle.
module nms_line_buffer
  import nms_pkg::*;
#(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned IMG_W = 640
) (
  input  logic             clk,
  input  logic             shift_en,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [DIR_W-1:0] in_dir,
  output logic [MAG_W-1:0] win_mag [3][3],
  output logic [DIR_W-1:0] ctr_dir
);
  localparam int unsigned MagDepth = 2 * IMG_W + 2;
  localparam int unsigned DirDepth = IMG_W + 1;

  logic [MAG_W-1:0] mag_q [MagDepth];
  logic [DIR_W-1:0] dir_q [DirDepth];

  // Contents are not reset; border suppression hides stale data after a frame start.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mag_q[0] <= in_mag;
      dir_q[0] <= in_dir;
      for (int k = 1; k < MagDepth; k++) mag_q[k] <= mag_q[k-1];
      for (int k = 1; k < DirDepth; k++) dir_q[k] <= dir_q[k-1];
    end
  end

  // mag_q[k] is the pixel k+1 steps before the incoming one; centre sits IMG_W+1 back.
  always_comb begin
    win_mag[0][0] = mag_q[2*IMG_W+1];
    win_mag[0][1] = mag_q[2*IMG_W];
    win_mag[0][2] = mag_q[2*IMG_W-1];
    win_mag[1][0] = mag_q[IMG_W+1];
    win_mag[1][1] = mag_q[IMG_W];
    win_mag[1][2] = mag_q[IMG_W-1];
    win_mag[2][0] = mag_q[1];
    win_mag[2][1] = mag_q[0];
    win_mag[2][2] = in_mag;
    ctr_dir       = dir_q[IMG_W];
  end

endmodule

// File: rtl/nms_stream_pipe.sv
// Streaming Canny non-maximal suppression with IMG_W+1 pixel lag and end-of-frame drain.
// Optional low threshold on interior results when NMS_THRESH_EN is defined.
module nms_stream_pipe
  import nms_pkg::*;
#(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  nms_stream_pipe_if.slave s,
`ifdef NMS_THRESH_EN
  input  logic [MAG_W-1:0] thresh_lo,
`endif
  output logic             busy
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned DW = $clog2(IMG_W + 2);

  localparam logic [CW-1:0] ColLast   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast   = RW'(IMG_H - 1);
  localparam logic [DW-1:0] DrainLast = DW'(IMG_W);
  localparam logic [DW-1:0] DrainDone = DW'(IMG_W + 1);

  nms_state_t       state_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [DW-1:0]    drain_cnt_q;
  logic             out_valid_q;
  logic [MAG_W-1:0] out_mag_q;
  logic             out_sof_q;
  logic             out_eof_q;

  logic             slot_free;
  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic [MAG_W-1:0] win_mag [3][3];
  logic [DIR_W-1:0] ctr_dir;
  logic [MAG_W-1:0] nb_a;
  logic [MAG_W-1:0] nb_b;
  logic [MAG_W-1:0] ctr_mag;
  logic             keep;
  logic             interior;
  logic [MAG_W-1:0] result;
  logic             sof_out;
  logic             last_px;

  assign slot_free = !out_valid_q || s.out_ready;
  assign in_ready  = (state_q != DRAIN) && slot_free;
  assign in_fire   = s.in_valid && in_ready;
  assign out_fire  = out_valid_q && s.out_ready;

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_mag   = out_mag_q;
  assign s.out_sof   = out_sof_q;
  assign s.out_eof   = out_eof_q;
  assign busy        = (state_q != IDLE);

  nms_line_buffer #(
    .MAG_W (MAG_W),
    .IMG_W (IMG_W)
  ) u_line_buffer (
    .clk      (clk),
    .shift_en (in_fire),
    .in_mag   (s.in_mag),
    .in_dir   (s.in_dir),
    .win_mag  (win_mag),
    .ctr_dir  (ctr_dir)
  );

  // Accepting (row_q, col_q) completes the window for centre (row_q-1, col_q-1);
  // col_q >= 2 also excludes the wrapped case where the centre lands in the last column.
  assign interior = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign sof_out  = (row_q == RW'(1)) && (col_q == CW'(1));
  assign last_px  = (row_q == RowLast) && (col_q == ColLast);
  assign ctr_mag  = win_mag[1][1];

  always_comb begin
    nb_a = win_mag[1][0];
    nb_b = win_mag[1][2];
    unique case (nms_dir_t'(ctr_dir))
      DIR_0: begin
        nb_a = win_mag[1][0];
        nb_b = win_mag[1][2];
      end
      DIR_45: begin
        nb_a = win_mag[0][2];
        nb_b = win_mag[2][0];
      end
      DIR_90: begin
        nb_a = win_mag[0][1];
        nb_b = win_mag[2][1];
      end
      DIR_135: begin
        nb_a = win_mag[0][0];
        nb_b = win_mag[2][2];
      end
    endcase
    keep = (ctr_mag >= nb_a) && (ctr_mag >= nb_b);
`ifdef NMS_THRESH_EN
    keep = keep && (ctr_mag >= thresh_lo);
`endif
    result = (interior && keep) ? ctr_mag : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      drain_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      if (out_fire) out_valid_q <= 1'b0;

      if (in_fire) begin
        if (s.in_sof) begin
          // New frame (or abort): the pending output register is left untouched.
          state_q <= FILL;
          col_q   <= CW'(1);
          row_q   <= '0;
        end else if (state_q != IDLE) begin
          if (col_q == ColLast) begin
            col_q <= '0;
            row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
          if (state_q == FILL && row_q == RW'(1) && col_q == '0) state_q <= RUN;
          if (state_q == RUN) begin
            out_valid_q <= 1'b1;
            out_mag_q   <= result;
            out_sof_q   <= sof_out;
            out_eof_q   <= 1'b0;
            if (last_px) begin
              state_q     <= DRAIN;
              drain_cnt_q <= '0;
            end
          end
        end
      end

      if (state_q == DRAIN) begin
        if (slot_free && drain_cnt_q != DrainDone) begin
          out_valid_q <= 1'b1;
          out_mag_q   <= '0;
          out_sof_q   <= 1'b0;
          out_eof_q   <= (drain_cnt_q == DrainLast);
          drain_cnt_q <= drain_cnt_q + 1'b1;
        end
        if (out_fire && out_eof_q) state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_nms_stream_pipe.sv
// Directed + scoreboard bench for nms_stream_pipe on a 5x5 frame.
module tb_nms_stream_pipe;
  import nms_pkg::*;

  localparam int W = 5;
  localparam int H = 5;

  typedef struct packed {
    logic [7:0] mag;
    logic       sof;
    logic       eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [7:0] thresh;

  nms_stream_pipe_if #(.MAG_W(8)) bus ();

  nms_stream_pipe #(
    .MAG_W (8),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus),
`ifdef NMS_THRESH_EN
    .thresh_lo (thresh),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   out_log [64];
  int   out_idx = 0;
  int   orm = 0;          // out_ready mode: 0 always, 1 random, 2 held low
  bit   draining = 1'b0;
  bit   stalled = 1'b0;
  exp_t held;

  logic [7:0] img_mag [H][W];
  logic [1:0] img_dir [H][W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mag(input int idx);
    int r, c;
    logic [7:0] m, a, b;
    r = idx / W;
    c = idx % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    m = img_mag[r][c];
    case (img_dir[r][c])
      2'd0: begin a = img_mag[r][c-1];   b = img_mag[r][c+1];   end
      2'd1: begin a = img_mag[r-1][c+1]; b = img_mag[r+1][c-1]; end
      2'd2: begin a = img_mag[r-1][c];   b = img_mag[r+1][c];   end
      default: begin a = img_mag[r-1][c-1]; b = img_mag[r+1][c+1]; end
    endcase
`ifdef NMS_THRESH_EN
    if (m < thresh) return 8'd0;
`endif
    return (m >= a && m >= b) ? m : 8'd0;
  endfunction

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{ref_mag(i), i == 0, i == W * H - 1});
  endtask

  task automatic fill_img(input logic [7:0] m, input logic [1:0] d);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img_mag[r][c] = m;
        img_dir[r][c] = d;
      end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_pixel(input logic [7:0] m, input logic [1:0] d, input logic sof);
    int n;
    logic rdy;
    if (orm == 1 && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_mag   = m;
    bus.in_dir   = d;
    bus.in_sof   = sof;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    chk("accept", rdy, 1'b1);
    bus.in_sof = 1'b0;
  endtask

  task automatic send_frame(input int npix);
    for (int i = 0; i < npix; i++) send_pixel(img_mag[i / W][i % W], img_dir[i / W][i % W], i == 0);
    if (npix == W * H) draining = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 400, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_full(input string tag);
    out_idx = 0;
    push_frame(W * H);
    send_frame(W * H);
    wait_done(tag);
    chk({tag, "_count"}, out_idx, W * H);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (orm == 1)      bus.out_ready = 1'($urandom_range(0, 1));
      else if (orm == 0) bus.out_ready = 1'b1;
      else               bus.out_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", {bus.out_valid, bus.out_mag, bus.out_sof, bus.out_eof}, {1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out", {bus.out_mag, bus.out_sof, bus.out_eof}, e);
          if (out_idx < 64) out_log[out_idx] = int'(bus.out_mag);
          out_idx++;
        end
      end
      if (draining) begin
        chk("drain_in_ready", bus.in_ready, 1'b0);
        if (bus.out_valid && bus.out_ready && bus.out_eof) draining = 1'b0;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = '{bus.out_mag, bus.out_sof, bus.out_eof};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    thresh       = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_mag   = '0;
    bus.in_dir   = '0;
    bus.in_sof   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_mag", bus.out_mag, 8'd0);
    chk("rst_sof_eof", {bus.out_sof, bus.out_eof}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pixels without sof in IDLE are dropped.
    send_pixel(8'd77, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_drop_busy", busy, 1'b0);
    @(posedge clk);
    #1;

    // 1: flat frame, ties kept.
    fill_img(8'd10, 2'd0);
    run_full("flat");
    chk("flat_interior", out_log[12], 10);
    chk("flat_border", out_log[5], 0);

    // 2: vertical peak suppressed, then kept.
    fill_img(8'd0, 2'd2);
    img_mag[2][2] = 8'd90;
    img_mag[1][2] = 8'd110;
    img_mag[3][2] = 8'd70;
    run_full("peak_a");
    chk("peak_supp", out_log[12], 0);
    img_mag[1][2] = 8'd50;
    run_full("peak_b");
    chk("peak_keep", out_log[12], 90);

    // 3: horizontal ridge.
    fill_img(8'd0, 2'd0);
    img_mag[2][1] = 8'd30;
    img_mag[2][2] = 8'd90;
    img_mag[2][3] = 8'd89;
    run_full("ridge");
    chk("ridge_21", out_log[11], 0);
    chk("ridge_22", out_log[12], 90);
    chk("ridge_23", out_log[13], 0);

    // 4: random image, random backpressure and input gaps.
    orm = 1;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          img_mag[r][c] = 8'($urandom_range(0, 255));
          img_dir[r][c] = 2'($urandom_range(0, 3));
        end
      run_full("rand");
    end
    orm = 0;

    // 5: abort at (2,3) then a full frame; the aborted frame yields 7 outputs and no eof.
    out_idx = 0;
    push_frame(7);
    send_frame(13);
    push_frame(W * H);
    send_frame(W * H);
    wait_done("abort");
    chk("abort_count", out_idx, 7 + W * H);

    // rst mid-frame with an output stalled in the register.
    out_idx = 0;
    push_frame(6);
    send_frame(12);
    orm = 2;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_pending", exp_q.size(), 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    orm = 0;
    bus.out_ready = 1'b1;
    fill_img(8'd10, 2'd0);
    run_full("post_rst");

`ifdef NMS_THRESH_EN
    // 6: threshold on the ridge.
    fill_img(8'd0, 2'd0);
    img_mag[2][1] = 8'd30;
    img_mag[2][2] = 8'd90;
    img_mag[2][3] = 8'd89;
    thresh = 8'd100;
    run_full("thr100");
    chk("thr100_22", out_log[12], 0);
    thresh = 8'd90;
    run_full("thr90");
    chk("thr90_22", out_log[12], 90);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
